// File: rtl/onchip_mem_arbiter.sv
// Round-robin arbiter sharing the on-chip memory port between requesters A and B.
// One access in flight; reads return a fixed READ_LATENCY+1 cycles after the command.
module onchip_mem_arbiter #(
    parameter int ADDR_W       = 17,
    parameter int DATA_W       = 32,
    parameter int READ_LATENCY = 2
) (
    input  logic                clk_clk,
    input  logic                reset_reset,
    input  logic                a_req,
    input  logic                a_we,
    input  logic [ADDR_W-1:0]   a_addr,
    input  logic [DATA_W-1:0]   a_wdata,
    input  logic [DATA_W/8-1:0] a_be,
    output logic                a_gnt,
    output logic                a_rvalid,
    output logic [DATA_W-1:0]   a_rdata,
    input  logic                b_req,
    input  logic                b_we,
    input  logic [ADDR_W-1:0]   b_addr,
    input  logic [DATA_W-1:0]   b_wdata,
    input  logic [DATA_W/8-1:0] b_be,
    output logic                b_gnt,
    output logic                b_rvalid,
    output logic [DATA_W-1:0]   b_rdata,
    output logic                busy,
    output logic [ADDR_W-1:0]   mem_address,
    output logic                mem_chipselect,
    output logic                mem_clken,
    output logic                mem_write,
    output logic [DATA_W-1:0]   mem_writedata,
    output logic [DATA_W/8-1:0] mem_byteenable,
    input  logic [DATA_W-1:0]   mem_readdata
);
    localparam int BE_W  = DATA_W / 8;
    localparam int CNT_W = 2;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ISSUE   = 2'd1;
    localparam logic [1:0] S_WAIT_RD = 2'd2;

    logic [1:0]        r_state;
    logic              r_last_b;
    logic              r_win_b;
    logic              r_win_we;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_a_gnt;
    logic              r_b_gnt;
    logic              r_a_rvalid;
    logic              r_b_rvalid;
    logic [DATA_W-1:0] r_a_rdata;
    logic [DATA_W-1:0] r_b_rdata;
    logic [ADDR_W-1:0] r_mem_address;
    logic              r_mem_chipselect;
    logic              r_mem_clken;
    logic              r_mem_write;
    logic [DATA_W-1:0] r_mem_writedata;
    logic [BE_W-1:0]   r_mem_byteenable;

    logic              w_any;
    logic              w_win_b;
    logic              w_we;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_wdata;
    logic [BE_W-1:0]   w_be;

    // On a tie the port that did not win last time is chosen.
    assign w_any   = a_req | b_req;
    assign w_win_b = b_req & (~a_req | ~r_last_b);
    assign w_we    = w_win_b ? b_we    : a_we;
    assign w_addr  = w_win_b ? b_addr  : a_addr;
    assign w_wdata = w_win_b ? b_wdata : a_wdata;
    assign w_be    = w_win_b ? b_be    : a_be;

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            r_state          <= S_IDLE;
            r_last_b         <= 1'b1;
            r_win_b          <= 1'b0;
            r_win_we         <= 1'b0;
            r_cnt            <= '0;
            r_a_gnt          <= 1'b0;
            r_b_gnt          <= 1'b0;
            r_a_rvalid       <= 1'b0;
            r_b_rvalid       <= 1'b0;
            r_a_rdata        <= '0;
            r_b_rdata        <= '0;
            r_mem_address    <= '0;
            r_mem_chipselect <= 1'b0;
            r_mem_clken      <= 1'b0;
            r_mem_write      <= 1'b0;
            r_mem_writedata  <= '0;
            r_mem_byteenable <= '0;
        end else begin
            r_mem_clken <= 1'b1;
            r_a_gnt     <= 1'b0;
            r_b_gnt     <= 1'b0;
            r_a_rvalid  <= 1'b0;
            r_b_rvalid  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_state          <= S_ISSUE;
                        r_win_b          <= w_win_b;
                        r_last_b         <= w_win_b;
                        r_win_we         <= w_we;
                        r_mem_address    <= w_addr;
                        r_mem_writedata  <= w_wdata;
                        r_mem_byteenable <= w_we ? w_be : '1;
                        r_mem_chipselect <= 1'b1;
                        r_mem_write      <= w_we;
                        r_a_gnt          <= ~w_win_b;
                        r_b_gnt          <= w_win_b;
                    end
                end
                S_ISSUE: begin
                    r_mem_chipselect <= 1'b0;
                    r_mem_write      <= 1'b0;
                    if (r_win_we) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_state <= S_WAIT_RD;
                        r_cnt   <= CNT_W'(READ_LATENCY - 1);
                    end
                end
                S_WAIT_RD: begin
                    if (r_cnt == '0) begin
                        r_state <= S_IDLE;
                        if (r_win_b) begin
                            r_b_rdata  <= mem_readdata;
                            r_b_rvalid <= 1'b1;
                        end else begin
                            r_a_rdata  <= mem_readdata;
                            r_a_rvalid <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy           = (r_state != S_IDLE);
    assign a_gnt          = r_a_gnt;
    assign b_gnt          = r_b_gnt;
    assign a_rvalid       = r_a_rvalid;
    assign b_rvalid       = r_b_rvalid;
    assign a_rdata        = r_a_rdata;
    assign b_rdata        = r_b_rdata;
    assign mem_address    = r_mem_address;
    assign mem_chipselect = r_mem_chipselect;
    assign mem_clken      = r_mem_clken;
    assign mem_write      = r_mem_write;
    assign mem_writedata  = r_mem_writedata;
    assign mem_byteenable = r_mem_byteenable;

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Bench for onchip_mem_arbiter: three instances (READ_LATENCY 1..3), each with a RAM
// model and a transaction-level reference that predicts grants, bus commands and read returns.
module tb_onchip_mem_arbiter;
    typedef struct {
        bit          we;
        logic [16:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } cmd_t;

    typedef struct {
        int unsigned cyc;
        bit          port_b;
        logic [31:0] data;
    } rd_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    cmd_t dir_a[$];
    cmd_t dir_b[$];

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] init_word(input logic [16:0] a);
        return (32'h9E3779B1 * {15'd0, a}) ^ 32'hC0FFEE00;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] be);
        logic [31:0] m;
        m = old;
        for (int i = 0; i < 4; i++)
            if (be[i]) m[8*i +: 8] = wd[8*i +: 8];
        return m;
    endfunction

    function automatic cmd_t rand_cmd();
        cmd_t c;
        c.we    = 1'($urandom_range(0, 1));
        c.wdata = $urandom;
        c.be    = 4'($urandom);
        case ($urandom_range(0, 4))
            0:       c.addr = 17'h00010;
            1:       c.addr = 17'h00020;
            2:       c.addr = 17'h1FFFF;
            3:       c.addr = 17'h00000;
            default: c.addr = 17'($urandom);
        endcase
        return c;
    endfunction

    function automatic cmd_t mk(input bit we, input logic [16:0] a, input logic [31:0] d,
                                input logic [3:0] be);
        cmd_t c;
        c.we = we; c.addr = a; c.wdata = d; c.be = be;
        return c;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_rl
        localparam int RL = g + 1;

        logic [1:0]  req, we, gnt, rvalid;
        logic [16:0] addr_in [2];
        logic [31:0] wdata_in [2];
        logic [3:0]  be_in [2];
        logic [31:0] a_rdata, b_rdata, wd, rd;
        logic [16:0] addr;
        logic [3:0]  be;
        logic        busy, cs, clken, wr;

        onchip_mem_arbiter #(.ADDR_W(17), .DATA_W(32), .READ_LATENCY(RL)) dut (
            .clk_clk(clk), .reset_reset(rst),
            .a_req(req[0]), .a_we(we[0]), .a_addr(addr_in[0]), .a_wdata(wdata_in[0]),
            .a_be(be_in[0]), .a_gnt(gnt[0]), .a_rvalid(rvalid[0]), .a_rdata(a_rdata),
            .b_req(req[1]), .b_we(we[1]), .b_addr(addr_in[1]), .b_wdata(wdata_in[1]),
            .b_be(be_in[1]), .b_gnt(gnt[1]), .b_rvalid(rvalid[1]), .b_rdata(b_rdata),
            .busy(busy), .mem_address(addr), .mem_chipselect(cs), .mem_clken(clken),
            .mem_write(wr), .mem_writedata(wd), .mem_byteenable(be), .mem_readdata(rd)
        );

        // Memory model: data for a read command appears RL cycles later; noise otherwise.
        logic [31:0] ram [logic [16:0]];
        logic [31:0] pipe [RL];
        always @(posedge clk) begin
            if (clken && cs && wr)
                ram[addr] = merge(ram.exists(addr) ? ram[addr] : init_word(addr), wd, be);
            pipe[0] <= (clken && cs && !wr) ? (ram.exists(addr) ? ram[addr] : init_word(addr))
                                            : $urandom;
            for (int i = 1; i < RL; i++) pipe[i] <= pipe[i-1];
        end
        assign rd = pipe[RL-1];

        logic [31:0] ref_mem [logic [16:0]];
        rd_t         pend[$];
        int unsigned cyc, free_from;
        int unsigned ia = 0, ib = 0;
        bit          last_b, force_rd, wb, issue, have;
        cmd_t        c;
        logic [31:0] old;
        logic        e_ga, e_gb, e_cs, e_we, e_clk, e_rva, e_rvb;
        logic [16:0] e_addr;
        logic [31:0] e_wd, e_ra, e_rb;
        logic [3:0]  e_be;

        always @(negedge clk or posedge rst) begin
            if (rst) begin
                #1;
                check($sformatf("rl%0d rst_ctrl", RL),
                      {gnt, rvalid, busy, cs, clken, wr}, 64'd0);
                check($sformatf("rl%0d rst_rdata", RL), {a_rdata, b_rdata}, 64'd0);
                check($sformatf("rl%0d rst_bus", RL), {addr, be, wd}, 64'd0);
                req = '0; we = '0;
                pend.delete();
                {e_ga, e_gb, e_cs, e_we, e_clk} = '0;
                e_ra = '0; e_rb = '0;
                last_b = 1'b1; cyc = 0; free_from = 0;
                if (ia >= dir_a.size()) force_rd = 1'b1;
            end else begin
                e_rva = 1'b0; e_rvb = 1'b0;
                if (pend.size() > 0 && pend[0].cyc == cyc) begin
                    if (pend[0].port_b) begin e_rvb = 1'b1; e_rb = pend[0].data; end
                    else                begin e_rva = 1'b1; e_ra = pend[0].data; end
                    void'(pend.pop_front());
                end
                check($sformatf("rl%0d gnt", RL), gnt, {e_gb, e_ga});
                check($sformatf("rl%0d cs_wr", RL), {cs, wr}, {e_cs, e_we});
                check($sformatf("rl%0d clken", RL), clken, e_clk);
                check($sformatf("rl%0d busy", RL), busy, cyc < free_from);
                check($sformatf("rl%0d rvalid", RL), rvalid, {e_rvb, e_rva});
                check($sformatf("rl%0d a_rdata", RL), a_rdata, e_ra);
                check($sformatf("rl%0d b_rdata", RL), b_rdata, e_rb);
                if (e_cs) begin
                    check($sformatf("rl%0d addr_be", RL), {addr, be}, {e_addr, e_be});
                    if (e_we) check($sformatf("rl%0d wdata", RL), wd, e_wd);
                end

                // Requesters hold until granted, then present their next command at once.
                for (int p = 0; p < 2; p++) begin
                    issue = 1'b0; have = 1'b0;
                    if (gnt[p]) begin
                        req[p] = 1'b0; issue = 1'b1;
                    end else if (req[p] && ib >= dir_b.size() && ia >= dir_a.size()
                                 && $urandom_range(0, 15) == 0) begin
                        req[p] = 1'b0;
                    end else if (!req[p]) begin
                        issue = 1'b1;
                    end
                    if (issue) begin
                        if (p == 0 && ia < dir_a.size()) begin
                            c = dir_a[ia]; ia++; have = 1'b1;
                        end else if (p == 1 && ib < dir_b.size()) begin
                            c = dir_b[ib]; ib++; have = 1'b1;
                        end else if (p == 0 && force_rd) begin
                            c = mk(1'b0, 17'h00010, 32'h0, 4'hF); force_rd = 1'b0; have = 1'b1;
                        end else if (ia >= dir_a.size() && ib >= dir_b.size()
                                     && $urandom_range(0, 2) != 0) begin
                            c = rand_cmd(); have = 1'b1;
                        end
                        if (have) begin
                            req[p] = 1'b1; we[p] = c.we; addr_in[p] = c.addr;
                            wdata_in[p] = c.wdata; be_in[p] = c.be;
                        end
                    end
                end

                // Predict the next cycle from what the arbiter will sample at this edge.
                {e_ga, e_gb, e_cs, e_we} = '0;
                e_clk = 1'b1;
                if (cyc >= free_from && req != 2'b00) begin
                    wb = req[1] && (!req[0] || !last_b);
                    last_b = wb;
                    e_ga = !wb; e_gb = wb; e_cs = 1'b1; e_we = we[wb];
                    e_addr = addr_in[wb]; e_wd = wdata_in[wb];
                    e_be = we[wb] ? be_in[wb] : 4'hF;
                    old = ref_mem.exists(addr_in[wb]) ? ref_mem[addr_in[wb]] : init_word(addr_in[wb]);
                    if (we[wb]) begin
                        ref_mem[addr_in[wb]] = merge(old, wdata_in[wb], be_in[wb]);
                        free_from = cyc + 2;
                    end else begin
                        pend.push_back('{cyc + 2 + RL, wb, old});
                        free_from = cyc + 2 + RL;
                    end
                end
                cyc++;
            end
        end
    end

    initial begin
        bit found;
        dir_a.push_back(mk(1'b1, 17'h00010, 32'hDEADBEEF, 4'hF));
        dir_a.push_back(mk(1'b0, 17'h00010, 32'h0, 4'hF));
        dir_a.push_back(mk(1'b1, 17'h00030, 32'hCAFEF00D, 4'h3));
        dir_a.push_back(mk(1'b0, 17'h00030, 32'h0, 4'hF));
        dir_a.push_back(mk(1'b0, 17'h00010, 32'h0, 4'hF));
        dir_a.push_back(mk(1'b1, 17'h00020, 32'h01020304, 4'hC));
        dir_b.push_back(mk(1'b0, 17'h00020, 32'h0, 4'hF));
        dir_b.push_back(mk(1'b1, 17'h1FFFF, 32'h11223344, 4'hF));
        dir_b.push_back(mk(1'b1, 17'h1FFFF, 32'h00AB0000, 4'h4));
        dir_b.push_back(mk(1'b0, 17'h1FFFF, 32'h0, 4'hF));
        dir_b.push_back(mk(1'b0, 17'h00010, 32'h0, 4'hF));
        dir_b.push_back(mk(1'b1, 17'h00040, 32'hA5A5A5A5, 4'hF));

        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        repeat (400) @(posedge clk);

        // Hit the RL=2 instance while it waits on a read return.
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(posedge clk);
            #2;
            if (g_rl[1].busy && !g_rl[1].cs) found = 1'b1;
        end
        check("rst_in_wait_rd", found, 1'b1);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        repeat (400) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
